memory_cycle: RTL and testbench
===============================

MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have port clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have M-stage inputs RegWriteM 1, ResultSrcM 1 (1=load), MemWriteM 1, funct3M 3, RdM 5, PCPlus4M 32, ALU_ResultM 32 (address/result), WriteDataM 32.
REQ-004 SHALL have data-memory outputs dmem_req 1, dmem_we 1, dmem_addr 32, dmem_wdata 32, dmem_be 4.
REQ-005 SHALL have data-memory inputs dmem_rdata 32 and dmem_ack 1 (one-cycle completion pulse).
REQ-006 SHALL have W-stage outputs RegWriteW 1, ResultSrcW 1, RdW 5, PCPlus4W 32, ALU_ResultW 32, ReadDataW 32, MisalignW 1, all registered.
REQ-007 SHALL have output StallM 1 (combinational; upstream holds M inputs stable while high).

Function
REQ-008 SHALL classify an access as ResultSrcM | MemWriteM; MemWriteM takes priority over ResultSrcM if both are high.
REQ-009 SHALL flag misalignment when the halfword size (funct3M[1:0]=01) has addr[0]=1, or the word size (funct3M[1:0]=10) has addr[1:0]!=0.
REQ-010 SHALL implement FSM states IDLE and BUSY.
REQ-011 SHALL pass a non-access or misaligned instruction in IDLE to the W registers at the next edge, with StallM=0 (1-cycle latency).
REQ-012 SHALL, for a misaligned access, issue no bus request and load MisalignW=1, RegWriteW=0 and ReadDataW=0.
REQ-013 SHALL, for an aligned access in IDLE, drive StallM=1, capture the M fields and go to BUSY at the next edge.
REQ-014 SHALL load a bubble into the W registers on that same edge: RegWriteW=0, MisalignW=0.
REQ-015 SHALL, in BUSY, hold dmem_req=1 with the captured dmem_addr, dmem_we, dmem_wdata and dmem_be stable until dmem_ack=1 is sampled.
REQ-016 SHALL, in BUSY with dmem_ack=0, keep StallM=1 and load a bubble into W on every edge.
REQ-017 SHALL, in BUSY with dmem_ack=1, drive StallM=0, load the captured fields plus formatted ReadDataW into W, and return to IDLE at that edge.
REQ-018 SHALL give an access a minimum latency of 2 cycles in M; a store's RegWriteW is taken from the captured RegWriteM.
REQ-019 SHALL drive dmem_req=0 in IDLE and ignore dmem_ack in IDLE.
REQ-020 SHALL format a load by byte lane addr[1:0]: LB 000 sign-extend byte, LH 001 sign-extend half, LW 010 word, LBU 100 zero-extend byte, LHU 101 zero-extend half; other codes are treated as LW.
REQ-021 SHALL set ReadDataW=0 for a non-load instruction.
REQ-022 SHALL drive dmem_addr as {addr[31:2],2'b00} and replicate store data across lanes: SB byte x4, SH half x2, SW word.
REQ-023 SHALL drive dmem_be as SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111, and 0000 for a load (dmem_we=0).
REQ-024 SHALL carry ALU_ResultW, PCPlus4W, RdW and ResultSrcW unmodified from the instruction being retired.

Reset
REQ-025 SHALL, while rst=1 (asynchronous): FSM=IDLE; dmem_req=0, dmem_we=0, dmem_be=0; all W outputs 0; StallM follows REQ-013 combinationally.
REQ-026 SHALL, on reset asserted mid-BUSY, drop dmem_req immediately, discard the access and never retire it.

Verification
REQ-027 SHALL cover ALU pass-through: RegWriteM=1, ALU_ResultM=0x1234, RdM=5, no access -> next cycle RegWriteW=1, ALU_ResultW=0x1234, RdW=5, StallM stays 0.
REQ-028 SHALL cover a waited LB: addr 0x103, LB, ack after 3 BUSY cycles, dmem_rdata=0x80AA5511 -> dmem_addr=0x100, be=0000; StallM high 4 cycles; ReadDataW=0xFFFFFF80.
REQ-029 SHALL cover an immediate-ack SH: addr 0x102, WriteDataM=0x0000BEEF, ack in the first BUSY cycle -> dmem_we=1, be=1100, wdata=0xBEEFBEEF; 2-cycle latency.
REQ-030 SHALL cover misalignment: LW at 0x101 -> dmem_req never asserts, MisalignW=1, RegWriteW=0, no stall.
REQ-031 SHALL cover back-to-back loads: second load begins in IDLE the cycle after the first ack; each request is issued once, in order.
REQ-032 SHALL cover reset mid-access: rst pulsed in BUSY -> dmem_req=0 asynchronously, W outputs 0, a later ack is ignored.

Source files
------------

// File: rtl/memory_cycle.sv
// Memory stage: drives the data bus for loads/stores and registers W-stage results.
// Ports: M-stage inputs, dmem request/response, registered W outputs, StallM.
module memory_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        MisalignW,
  output logic        StallM
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic        access, is_load, misalign, mis_acc, start;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;

  logic        rw_q, rs_q, ld_q, we_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_q, alu_q, wdata_q;
  logic [3:0]  be_q;

  logic        rw_d, rs_d, mis_d;
  logic [4:0]  rdw_d;
  logic [31:0] pcw_d, aluw_d, rdat_d;
  logic [31:0] fmt, sh_b;
  logic [15:0] half;

  // A store wins when both load and store are flagged.
  assign access  = ResultSrcM | MemWriteM;
  assign is_load = ResultSrcM & ~MemWriteM;

  always_comb begin
    misalign = 1'b0;
    unique case (funct3M[1:0])
      2'b01:   misalign = ALU_ResultM[0];
      2'b10:   misalign = |ALU_ResultM[1:0];
      default: misalign = 1'b0;
    endcase
  end

  assign mis_acc = access & misalign;
  assign start   = (state_q == IDLE) & access & ~misalign;

  always_comb begin
    be_n    = 4'b0000;
    wdata_n = WriteDataM;
    if (MemWriteM) begin
      unique case (funct3M[1:0])
        2'b00: begin
          be_n    = 4'b0001 << ALU_ResultM[1:0];
          wdata_n = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          be_n    = 4'b0011 << ALU_ResultM[1:0];
          wdata_n = {2{WriteDataM[15:0]}};
        end
        default: be_n = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q    <= 1'b0;
      rs_q    <= 1'b0;
      ld_q    <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      rd_q    <= 5'd0;
      pc_q    <= 32'd0;
      alu_q   <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else if (start) begin
      rw_q    <= RegWriteM;
      rs_q    <= ResultSrcM;
      ld_q    <= is_load;
      we_q    <= MemWriteM;
      f3_q    <= funct3M;
      rd_q    <= RdM;
      pc_q    <= PCPlus4M;
      alu_q   <= ALU_ResultM;
      wdata_q <= wdata_n;
      be_q    <= be_n;
    end
  end

  assign sh_b = dmem_rdata >> {alu_q[1:0], 3'b000};
  assign half = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    unique case (f3_q)
      3'b000:  fmt = {{24{sh_b[7]}}, sh_b[7:0]};
      3'b001:  fmt = {{16{half[15]}}, half};
      3'b100:  fmt = {24'd0, sh_b[7:0]};
      3'b101:  fmt = {16'd0, half};
      default: fmt = dmem_rdata;
    endcase
  end

  // Defaults form the bubble; only a pass-through or retire overrides.
  always_comb begin
    state_d = state_q;
    StallM  = 1'b0;
    rw_d    = 1'b0;
    rs_d    = 1'b0;
    mis_d   = 1'b0;
    rdw_d   = 5'd0;
    pcw_d   = 32'd0;
    aluw_d  = 32'd0;
    rdat_d  = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          StallM  = 1'b1;
          state_d = BUSY;
        end else begin
          rw_d   = RegWriteM & ~mis_acc;
          rs_d   = ResultSrcM;
          mis_d  = mis_acc;
          rdw_d  = RdM;
          pcw_d  = PCPlus4M;
          aluw_d = ALU_ResultM;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_d = IDLE;
          rw_d    = rw_q;
          rs_d    = rs_q;
          rdw_d   = rd_q;
          pcw_d   = pc_q;
          aluw_d  = alu_q;
          rdat_d  = ld_q ? fmt : 32'd0;
        end else begin
          StallM = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      MisalignW   <= 1'b0;
      RdW         <= 5'd0;
      PCPlus4W    <= 32'd0;
      ALU_ResultW <= 32'd0;
      ReadDataW   <= 32'd0;
    end else begin
      state_q     <= state_d;
      RegWriteW   <= rw_d;
      ResultSrcW  <= rs_d;
      MisalignW   <= mis_d;
      RdW         <= rdw_d;
      PCPlus4W    <= pcw_d;
      ALU_ResultW <= aluw_d;
      ReadDataW   <= rdat_d;
    end
  end

  assign dmem_req   = (state_q == BUSY);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_be    = dmem_req ? be_q : 4'b0000;
  assign dmem_addr  = {alu_q[31:2], 2'b00};
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: constant vector table, corner sequences and
// randomized accesses checked against a behavioural model.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, ResultSrcM, MemWriteM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  logic        MisalignW, StallM;

  int nvec = 0;
  int nerr = 0;

  memory_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .funct3M(funct3M),
    .RdM(RdM), .PCPlus4M(PCPlus4M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .MisalignW(MisalignW), .StallM(StallM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rw, ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    int          dly;
    logic [31:0] e_rd;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_mis;
  } vec_t;

  // Behavioural model
  function automatic logic m_mis(logic [2:0] f3, logic [31:0] a);
    if (f3[1:0] == 2'b01) return (a % 2) != 0;
    if (f3[1:0] == 2'b10) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a,
                                         logic [31:0] d);
    int v;
    case (f3)
      3'b000, 3'b100: begin
        v = int'((d >> (8 * (a % 4))) & 32'hFF);
        if (f3 == 3'b000 && v > 127) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = int'((d >> (16 * ((a / 2) % 2))) & 32'hFFFF);
        if (f3 == 3'b001 && v > 32767) v = v - 65536;
      end
      default: v = int'(d);
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 4'(1 << (a % 4));
      2'b01:   return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(logic [2:0] f3, logic [31:0] d);
    case (f3[1:0])
      2'b00:   return (d & 32'hFF) * 32'h01010101;
      2'b01:   return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  task automatic chk_bubble(input string nm);
    chk({nm, ".bub_rw"}, 32'(RegWriteW), 0);
    chk({nm, ".bub_mis"}, 32'(MisalignW), 0);
  endtask

  task automatic chk_bus(input string nm, input vec_t v);
    chk({nm, ".req"}, 32'(dmem_req), 1);
    chk({nm, ".addr"}, dmem_addr, v.addr & ~32'd3);
    chk({nm, ".we"}, 32'(dmem_we), 32'(v.st));
    chk({nm, ".be"}, 32'(dmem_be), 32'(v.e_be));
    if (v.st) chk({nm, ".wdata"}, dmem_wdata, v.e_wd);
  endtask

  // Applies one instruction at posedge+1; returns after it retires.
  task automatic run_op(input string nm, input vec_t v,
                        input logic [4:0] rd, input logic [31:0] pc);
    logic acc;
    acc = v.ld | v.st;
    RegWriteM = v.rw; ResultSrcM = v.ld; MemWriteM = v.st;
    funct3M = v.f3; RdM = rd; PCPlus4M = pc;
    ALU_ResultM = v.addr; WriteDataM = v.wd;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #1;
    chk({nm, ".req_idle"}, 32'(dmem_req), 0);
    if (!acc || v.e_mis) begin
      chk({nm, ".stall"}, 32'(StallM), 0);
    end else begin
      chk({nm, ".stall0"}, 32'(StallM), 1);
      @(posedge clk); #1;
      chk_bubble(nm);
      for (int i = 0; i < v.dly; i++) begin
        chk_bus(nm, v);
        chk({nm, ".stall_w"}, 32'(StallM), 1);
        @(posedge clk); #1;
        chk_bubble(nm);
      end
      chk_bus(nm, v);
      dmem_rdata = v.rdata; dmem_ack = 1'b1;
      #1;
      chk({nm, ".stall_ack"}, 32'(StallM), 0);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk({nm, ".RegWriteW"}, 32'(RegWriteW), 32'(v.rw & ~v.e_mis));
    chk({nm, ".ResultSrcW"}, 32'(ResultSrcW), 32'(v.ld));
    chk({nm, ".RdW"}, 32'(RdW), 32'(rd));
    chk({nm, ".PCPlus4W"}, PCPlus4W, pc);
    chk({nm, ".ALU_ResultW"}, ALU_ResultW, v.addr);
    chk({nm, ".ReadDataW"}, ReadDataW, v.e_rd);
    chk({nm, ".MisalignW"}, 32'(MisalignW), 32'(v.e_mis));
    chk({nm, ".req_after"}, 32'(dmem_req), 0);
  endtask

  vec_t tbl[14];
  vec_t r;

  initial begin
    //         rw  ld  st  f3      addr         wd           rdata        dly e_rd         e_be   e_wd         mis
    tbl[0]  = '{1, 0, 0, 3'b000, 32'h1234, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        0};
    tbl[1]  = '{1, 1, 0, 3'b000, 32'h103,  32'h0,        32'h80AA5511, 3, 32'hFFFFFF80, 4'h0, 32'h0,        0};
    tbl[2]  = '{0, 0, 1, 3'b001, 32'h102,  32'h0000BEEF, 32'h0,        0, 32'h0,        4'hC, 32'hBEEFBEEF, 0};
    tbl[3]  = '{1, 1, 0, 3'b010, 32'h101,  32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1};
    tbl[4]  = '{1, 1, 0, 3'b100, 32'h101,  32'h0,        32'h80AA5511, 1, 32'h00000055, 4'h0, 32'h0,        0};
    tbl[5]  = '{1, 1, 0, 3'b001, 32'h102,  32'h0,        32'h80AA5511, 0, 32'hFFFF80AA, 4'h0, 32'h0,        0};
    tbl[6]  = '{1, 1, 0, 3'b101, 32'h100,  32'h0,        32'h80AA5511, 2, 32'h00005511, 4'h0, 32'h0,        0};
    tbl[7]  = '{1, 1, 0, 3'b010, 32'h104,  32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'h0, 32'h0,        0};
    tbl[8]  = '{0, 0, 1, 3'b000, 32'h101,  32'h123456AB, 32'h0,        1, 32'h0,        4'h2, 32'hABABABAB, 0};
    tbl[9]  = '{1, 0, 1, 3'b010, 32'h200,  32'hCAFEF00D, 32'h0,        0, 32'h0,        4'hF, 32'hCAFEF00D, 0};
    tbl[10] = '{0, 0, 1, 3'b001, 32'h103,  32'h1111,     32'h0,        0, 32'h0,        4'h0, 32'h0,        1};
    tbl[11] = '{1, 1, 0, 3'b001, 32'h105,  32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        1};
    tbl[12] = '{1, 1, 1, 3'b000, 32'h102,  32'h77,       32'h0,        1, 32'h0,        4'h4, 32'h77777777, 0};
    tbl[13] = '{1, 1, 0, 3'b110, 32'h104,  32'h0,        32'h11223344, 0, 32'h11223344, 4'h0, 32'h0,        0};

    rst = 1'b1;
    RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0; funct3M = 0;
    RdM = 0; PCPlus4M = 0; ALU_ResultM = 0; WriteDataM = 0;
    dmem_rdata = 0; dmem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", 32'(dmem_req), 0);
    chk("rst.be", 32'(dmem_be), 0);
    chk("rst.we", 32'(dmem_we), 0);
    chk("rst.RegWriteW", 32'(RegWriteW), 0);
    chk("rst.ReadDataW", ReadDataW, 0);
    chk("rst.PCPlus4W", PCPlus4W, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Consecutive entries run back-to-back with no idle cycle between.
    for (int i = 0; i < 14; i++)
      run_op($sformatf("tbl%0d", i), tbl[i], 5'(i + 5),
             32'h1000 + 32'(4 * i));

    // Reset in the middle of a waited access.
    r = tbl[1];
    RegWriteM = 1; ResultSrcM = 1; MemWriteM = 0; funct3M = 3'b010;
    RdM = 5'd9; PCPlus4M = 32'h44; ALU_ResultM = 32'h300;
    @(posedge clk); #1;
    chk("mid.req_busy", 32'(dmem_req), 1);
    rst = 1'b1;
    #1;
    chk("mid.req_rst", 32'(dmem_req), 0);
    chk("mid.be_rst", 32'(dmem_be), 0);
    chk("mid.RdW", 32'(RdW), 0);
    RegWriteM = 0; ResultSrcM = 0; RdM = 0; PCPlus4M = 0; ALU_ResultM = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("mid.no_retire_rw", 32'(RegWriteW), 0);
    chk("mid.no_retire_rd", ReadDataW, 0);
    chk("mid.no_retire_RdW", 32'(RdW), 0);
    chk("mid.req_after", 32'(dmem_req), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      r.rw   = 1'($urandom);
      r.ld   = 1'($urandom);
      r.st   = 1'($urandom);
      r.f3   = 3'($urandom);
      if (r.st && r.f3[1:0] == 2'b11) r.f3[1:0] = 2'b10;
      r.addr = $urandom;
      r.wd   = $urandom;
      r.rdata = $urandom;
      r.dly  = int'($urandom_range(0, 3));
      r.e_mis = (r.ld | r.st) & m_mis(r.f3, r.addr);
      r.e_rd = (r.ld && !r.st && !r.e_mis)
               ? m_load(r.f3, r.addr, r.rdata) : 32'h0;
      r.e_be = r.st ? m_be(r.f3, r.addr) : 4'h0;
      r.e_wd = m_wd(r.f3, r.wd);
      run_op($sformatf("rnd%0d", i), r, 5'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
